// File: rtl/led_seq_ctrl_if.sv
// Command port of the LED sequencer.
// Valid/ready handshake with an op code and an 8-bit argument.
interface led_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_arg,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_arg,
    output cmd_ready
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED bar sequencer: base-tick divider, scan/chase/blink/off
// display modes, and a two-cycle command handshake.
module led_seq_ctrl #(
  parameter int NLEDS     = 8,
  parameter int SHIFT     = 16,
  parameter int DEF_SPEED = 7
) (
  input  logic             clk,
  input  logic             rstn,
  led_seq_ctrl_if.slave    cmd,
  input  logic             pause,
  output logic             tick,
  output logic [NLEDS-1:0] leds
);

  localparam int PW = (NLEDS > 2) ? $clog2(NLEDS) : 1;
  localparam int CW = 8 + SHIFT;

  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(NLEDS - 1);
  localparam logic [PW-1:0] P_PEN  = PW'(NLEDS - 2);

  localparam logic [NLEDS-1:0] L_ONE = NLEDS'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_SCAN  = 2'd1;
  localparam logic [1:0] M_CHASE = 2'd2;
  localparam logic [1:0] M_BLINK = 2'd3;

  localparam logic [1:0] OP_MODE  = 2'd0;
  localparam logic [1:0] OP_SPEED = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_PAT   = 2'd3;

  logic [0:0]       r_state;
  logic [1:0]       r_mode;
  logic [PW-1:0]    r_pos;
  logic             r_up;
  logic             r_phase;
  logic [7:0]       r_speed;
  logic [NLEDS-1:0] r_pattern;
  logic [CW-1:0]    r_cnt;

  logic [CW-1:0] w_div;
  logic [CW-1:0] w_cnt_n;
  logic          w_acc;
  logic          w_nat;
  logic          w_step;
  logic          w_restart;
  logic          w_adv;
  logic          w_op_mode;
  logic          w_op_speed;
  logic          w_op_step;
  logic          w_op_pat;
  logic [PW-1:0] w_pos_a;
  logic          w_up_a;
  logic          w_phase_a;

  // ((speed+1) << SHIFT) - 1 is speed followed by SHIFT ones
  assign w_div = {r_speed, {SHIFT{1'b1}}};

  assign w_op_mode  = (cmd.cmd_op == OP_MODE);
  assign w_op_speed = (cmd.cmd_op == OP_SPEED);
  assign w_op_step  = (cmd.cmd_op == OP_STEP);
  assign w_op_pat   = (cmd.cmd_op == OP_PAT);

  assign w_acc     = rstn & cmd.cmd_valid & (r_state == S_IDLE);
  assign w_nat     = ~pause & (r_cnt == w_div);
  assign w_step    = w_acc & w_op_step & pause;
  assign w_restart = w_acc & (w_op_mode | w_op_speed);

  assign tick          = w_nat | w_step;
  assign cmd.cmd_ready = (r_state == S_IDLE);

  always_comb begin
    w_cnt_n = r_cnt;
    if (!pause) begin
      w_cnt_n = w_nat ? '0 : r_cnt + CW'(1);
    end
  end

  // STEP always yields a single advance, even on a natural tick
  always_comb begin
    w_adv = w_nat;
    if (w_acc) begin
      unique case (1'b1)
        w_op_mode:  w_adv = 1'b0;
        w_op_speed: w_adv = 1'b0;
        w_op_step:  w_adv = pause | w_nat;
        w_op_pat:   w_adv = w_nat;
      endcase
    end
  end

  always_comb begin
    w_pos_a   = r_pos;
    w_up_a    = r_up;
    w_phase_a = r_phase;
    unique case (r_mode)
      M_OFF: begin
      end
      M_SCAN: begin
        if (r_up) begin
          if (r_pos == P_LAST) begin
            w_pos_a = P_PEN;
            w_up_a  = 1'b0;
          end else begin
            w_pos_a = r_pos + P_ONE;
          end
        end else begin
          if (r_pos == '0) begin
            w_pos_a = P_ONE;
            w_up_a  = 1'b1;
          end else begin
            w_pos_a = r_pos - P_ONE;
          end
        end
      end
      M_CHASE: begin
        w_pos_a = (r_pos == P_LAST) ? '0 : r_pos + P_ONE;
      end
      M_BLINK: begin
        w_phase_a = ~r_phase;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_mode    <= M_SCAN;
      r_pos     <= '0;
      r_up      <= 1'b1;
      r_phase   <= 1'b0;
      r_speed   <= 8'(DEF_SPEED);
      r_pattern <= '1;
      r_cnt     <= '0;
    end else begin
      r_state <= w_acc ? S_BUSY : S_IDLE;
      r_cnt   <= w_restart ? '0 : w_cnt_n;
      if (w_adv) begin
        r_pos   <= w_pos_a;
        r_up    <= w_up_a;
        r_phase <= w_phase_a;
      end
      if (w_acc && w_op_mode) begin
        r_mode  <= cmd.cmd_arg[1:0];
        r_pos   <= '0;
        r_up    <= 1'b1;
        r_phase <= 1'b0;
      end
      if (w_acc && w_op_speed) begin
        r_speed <= cmd.cmd_arg;
      end
      if (w_acc && w_op_pat) begin
        r_pattern <= cmd.cmd_arg[NLEDS-1:0];
      end
    end
  end

  always_comb begin
    leds = '0;
    unique case (r_mode)
      M_OFF:   leds = '0;
      M_SCAN:  leds = L_ONE << r_pos;
      M_CHASE: leds = L_ONE << r_pos;
      M_BLINK: leds = r_phase ? r_pattern : '0;
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: directed steps plus random commands,
// checked each cycle against a sequence-index reference model.
module tb_led_seq_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         pause;
  logic         tick;
  logic [N-1:0] leds;

  led_seq_ctrl_if cmd_if();

  led_seq_ctrl #(
    .NLEDS(N),
    .SHIFT(2),
    .DEF_SPEED(0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cmd(cmd_if),
    .pause(pause),
    .tick(tick),
    .leds(leds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         bounce[14];
  int         m_mode;
  int         m_k;
  int         m_speed;
  int         m_rem;
  logic [7:0] m_pat;
  bit         m_busy;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic m_reset();
    m_mode  = 1;
    m_k     = 0;
    m_speed = 0;
    m_pat   = 8'hFF;
    m_rem   = 4;
    m_busy  = 1'b0;
  endtask

  function automatic logic [7:0] exp_leds();
    logic [7:0] one;
    one = 8'h01;
    case (m_mode)
      1:       return one << bounce[m_k % 14];
      2:       return one << (m_k % 8);
      3:       return (m_k % 2 == 1) ? m_pat : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cyc(input bit v, input logic [1:0] op,
                     input logic [7:0] a, input bit p);
    bit acc;
    bit nat;
    bit adv;
    int per;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = a;
    pause            = p;
    acc = v && !m_busy;
    nat = !p && (m_rem == 1);
    @(negedge clk);
    chk("leds", leds, exp_leds());
    chk("ready", cmd_if.cmd_ready, !m_busy);
    chk("tick", tick, nat || (acc && op == 2'd2 && p));
    @(posedge clk);
    #1;
    adv = nat;
    if (acc) begin
      case (op)
        2'd0: begin
          adv    = 1'b0;
          m_mode = int'(a[1:0]);
          m_k    = 0;
        end
        2'd1: begin
          adv     = 1'b0;
          m_speed = int'(a);
        end
        2'd2: adv = p || nat;
        default: m_pat = a;
      endcase
    end
    if (adv && m_mode != 0) m_k++;
    per = (m_speed + 1) * 4;
    if (acc && op < 2'd2) m_rem = per;
    else if (!p) m_rem = nat ? per : m_rem - 1;
    m_busy = acc;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  initial begin
    bit         rv;
    bit         rp;
    logic [1:0] rop;
    logic [7:0] ra;

    for (int i = 0; i < 8; i++) bounce[i] = i;
    for (int i = 1; i < 7; i++) bounce[7 + i] = 7 - i;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_arg   = 8'h00;
    pause            = 1'b0;
    m_reset();

    #12;
    chk("rst_leds", leds, 8'h01);
    chk("rst_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_tick", tick, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // full bounce and back
    idle(64);

    // reach pos 5, then CHASE
    for (int i = 0; i < 64 && exp_leds() != 8'h20; i++) idle(1);
    chk("reach_pos5", leds, 8'h20);
    cyc(1'b1, 2'd0, 8'h02, 1'b0);
    chk("chase_start", leds, 8'h01);
    chk("busy_ready", cmd_if.cmd_ready, 1'b0);
    idle(40);

    // BLINK with pattern, then OFF
    cyc(1'b1, 2'd0, 8'h03, 1'b0);
    idle(1);
    cyc(1'b1, 2'd3, 8'hA5, 1'b0);
    idle(12);
    cyc(1'b1, 2'd0, 8'h00, 1'b0);
    idle(8);
    chk("off_leds", leds, 8'h00);

    // slower speed, then back-to-back valid
    cyc(1'b1, 2'd0, 8'h01, 1'b0);
    idle(1);
    cyc(1'b1, 2'd1, 8'h03, 1'b0);
    idle(40);
    repeat (10) cyc(1'b1, 2'd3, 8'($urandom), 1'b0);

    // pause, step, resume
    idle(5);
    repeat (50) cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b1, 2'd2, 8'h00, 1'b1);
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b1, 2'd2, 8'h00, 1'b1);
    idle(24);

    // STEP on a natural tick edge
    cyc(1'b1, 2'd1, 8'h00, 1'b0);
    idle(1);
    for (int i = 0; i < 8 && m_rem != 1; i++) idle(1);
    chk("tick_due", tick, 1'b1);
    cyc(1'b1, 2'd2, 8'h00, 1'b0);
    idle(6);

    // async reset while BUSY, between edges
    cyc(1'b1, 2'd0, 8'h02, 1'b0);
    idle(6);
    cyc(1'b1, 2'd3, 8'h0F, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_leds", leds, 8'h01);
    chk("arst_ready", cmd_if.cmd_ready, 1'b1);
    chk("arst_tick", tick, 1'b0);
    m_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(10);

    // random traffic
    repeat (400) begin
      rv  = ($urandom_range(0, 2) == 0);
      rp  = ($urandom_range(0, 3) == 0);
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      if (rop == 2'd1) ra = 8'($urandom_range(0, 3));
      cyc(rv, rop, ra, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
